decode_ctrl: RTL and testbench

Parametrised decode-stage pipeline controller for the CPU. It generalises the decode load-enable logic with three additions:
- an execute-stage ready handshake;
- load-use hazard stalling of configurable length;
- multi-cycle fetch flushing after jumps.

It also keeps saturating stall/flush performance counters. It sits between fetch/decode and the execute-stage pipeline registers (rx, ry, pc_ex, ir_ex).

---
 rtl/decode_ctrl.sv | 144 ++++++++++++++
 tb/tb_decode_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// Decode-stage pipeline controller: EX load enables, load-use stall, jump flush, perf counters.
// Latency: all control outputs are combinational (zero-cycle); state and counters update on clk.
// Backpressure: ex_ready=0 holds decode (id_stall) and freezes stall countdown; flush ignores it.
module decode_ctrl #(
  parameter int OPC_W        = 5,
  parameter int REG_W        = 3,
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rx,
  input  logic [REG_W-1:0] id_ry,
  input  logic             r_jump,
  input  logic             s_jump,
  input  logic             ex_ready,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             ld_rx,
  output logic             ld_ry,
  output logic             ld_pc_ex,
  output logic             ld_ir_ex,
  output logic             id_stall,
  output logic             if_flush,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic hazard, jump;
  logic ld_c, stall_c, flush_c, bubble_c;
  logic stall_inc, flush_inc;

  // Opcode is carried for debug visibility only; it never steers control.
  logic unused_opcode;
  assign unused_opcode = ^id_opcode;

  assign hazard = id_valid & ex_load & ((ex_rd == id_rx) | (ex_rd == id_ry));
  assign jump   = r_jump | s_jump;

  // Next-state and control decode; hazard outranks back-pressure, which outranks jump.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_c      = 1'b0;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (!id_valid) begin
          bubble_c = ex_ready;
        end else if (hazard) begin
          stall_c   = 1'b1;
          bubble_c  = ex_ready;
          stall_inc = 1'b1;
          if (ex_ready && (STALL_CYCLES > 1)) begin
            state_d = STALL;
            cnt_d   = CW'(STALL_CYCLES - 1);
          end
        end else if (!ex_ready) begin
          stall_c = 1'b1;
        end else if (jump) begin
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
          end
        end else begin
          ld_c = 1'b1;
        end
      end
      STALL: begin
        stall_c   = 1'b1;
        bubble_c  = ex_ready;
        stall_inc = 1'b1;
        if (ex_ready) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state register; reset aborts any stall/flush sequence in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating performance counters for hazard-stall cycles and accepted jumps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Combinational outputs are held low while reset is asserted, including the bubble.
  assign ld_rx     = reset & ld_c;
  assign ld_ry     = reset & ld_c;
  assign ld_pc_ex  = reset & ld_c;
  assign ld_ir_ex  = reset & ld_c;
  assign id_stall  = reset & stall_c;
  assign if_flush  = reset & flush_c;
  assign ex_bubble = reset & bubble_c;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl with STALL_CYCLES=3, FLUSH_CYCLES=2, CNT_W=3.
// Inputs change 1 time unit after the rising edge; outputs are compared mid-cycle.
// A cycle-count reference model (remaining stall/flush cycles) predicts every output.
module tb_decode_ctrl;

  localparam int OPC_W = 5;
  localparam int REG_W = 3;
  localparam int SC    = 3;
  localparam int FC    = 2;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [OPC_W-1:0] id_opcode;
  logic [REG_W-1:0] id_rx, id_ry, ex_rd;
  logic             r_jump, s_jump, ex_ready, ex_load;
  logic             ld_rx, ld_ry, ld_pc_ex, ld_ir_ex, id_stall, if_flush, ex_bubble;
  logic [CW-1:0]    stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles of stall / flush still owed, plus expected counter values.
  int m_stall = 0;
  int m_flush = 0;
  int m_scnt  = 0;
  int m_fcnt  = 0;

  always #5 clk = ~clk;

  decode_ctrl #(
    .OPC_W(OPC_W), .REG_W(REG_W), .STALL_CYCLES(SC), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rx(id_rx), .id_ry(id_ry), .r_jump(r_jump), .s_jump(s_jump),
    .ex_ready(ex_ready), .ex_load(ex_load), .ex_rd(ex_rd),
    .ld_rx(ld_rx), .ld_ry(ld_ry), .ld_pc_ex(ld_pc_ex), .ld_ir_ex(ld_ir_ex),
    .id_stall(id_stall), .if_flush(if_flush), .ex_bubble(ex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  // Check one cycle against the model, then advance model and clock together.
  task automatic step();
    logic e_ld, e_st, e_fl, e_bu, hz, jp;
    int   n_stall, n_flush, inc_s, inc_f;
    #3;
    e_ld = 0; e_st = 0; e_fl = 0; e_bu = 0; inc_s = 0; inc_f = 0;
    if (!reset) begin
      m_stall = 0; m_flush = 0; m_scnt = 0; m_fcnt = 0;
    end
    n_stall = m_stall;
    n_flush = m_flush;
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    if (!reset) begin
      // everything quiet
    end else if (m_flush > 0) begin
      e_fl = 1; e_bu = 1; n_flush = m_flush - 1;
    end else if (m_stall > 0) begin
      e_st = 1; e_bu = ex_ready; inc_s = 1;
      if (ex_ready) n_stall = m_stall - 1;
    end else begin
      hz = id_valid && ex_load && (ex_rd == id_rx || ex_rd == id_ry);
      jp = r_jump || s_jump;
      if (!id_valid) e_bu = ex_ready;
      else if (hz) begin
        e_st = 1; e_bu = ex_ready; inc_s = 1;
        if (ex_ready) n_stall = SC - 1;
      end else if (!ex_ready) e_st = 1;
      else if (jp) begin
        e_fl = 1; e_bu = 1; inc_f = 1; n_flush = FC - 1;
      end else e_ld = 1;
    end
    chk("ld_rx", 32'(ld_rx), 32'(e_ld));
    chk("ld_ry", 32'(ld_ry), 32'(e_ld));
    chk("ld_pc_ex", 32'(ld_pc_ex), 32'(e_ld));
    chk("ld_ir_ex", 32'(ld_ir_ex), 32'(e_ld));
    chk("id_stall", 32'(id_stall), 32'(e_st));
    chk("if_flush", 32'(if_flush), 32'(e_fl));
    chk("ex_bubble", 32'(ex_bubble), 32'(e_bu));
    if (reset) begin
      if (inc_s == 1 && m_scnt < CMAX) m_scnt++;
      if (inc_f == 1 && m_fcnt < CMAX) m_fcnt++;
      m_stall = n_stall;
      m_flush = n_flush;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REG_W-1:0] rx, input logic [REG_W-1:0] ry,
                       input logic rj, input logic sj, input logic rdy, input logic ldd,
                       input logic [REG_W-1:0] rd);
    id_valid  = v;
    id_rx     = rx;
    id_ry     = ry;
    r_jump    = rj;
    s_jump    = sj;
    ex_ready  = rdy;
    ex_load   = ldd;
    ex_rd     = rd;
    id_opcode = OPC_W'($urandom);
    step();
  endtask

  initial begin
    reset = 1'b0;
    drive(1, 1, 2, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    // Reset held with a valid instruction and ready EX: everything stays low.
    drive(1, 1, 2, 0, 0, 1, 0, 0);
    drive(1, 1, 2, 0, 1, 1, 1, 1);
    reset = 1'b1;
    drive(1, 1, 2, 0, 0, 1, 0, 5);
    // Straight-line flow.
    for (int i = 0; i < 10; i++) drive(1, 3'(i), 3'(i + 1), 0, 0, 1, 1, 3'(i + 2));
    // Load-use on ry=4: three hazard-stall cycles then the load has retired.
    repeat (3) drive(1, 1, 4, 0, 0, 1, 1, 4);
    drive(1, 1, 4, 0, 0, 1, 0, 4);
    // Same hazard with ex_ready dropped for two cycles mid-stall.
    drive(1, 4, 2, 0, 0, 1, 1, 4);
    drive(1, 4, 2, 0, 0, 0, 1, 4);
    drive(1, 4, 2, 0, 0, 0, 1, 4);
    drive(1, 4, 2, 0, 0, 1, 1, 4);
    drive(1, 4, 2, 0, 0, 1, 1, 4);
    drive(1, 4, 2, 0, 0, 1, 0, 4);
    // Static jump; an r_jump in the flush cycle must not extend it.
    drive(1, 1, 2, 0, 1, 1, 0, 0);
    drive(1, 1, 2, 1, 0, 1, 0, 0);
    drive(1, 1, 2, 0, 0, 1, 0, 0);
    // Register jump blocked by a hazard: stall first, then the jump is taken.
    repeat (3) drive(1, 6, 2, 1, 0, 1, 1, 6);
    drive(1, 6, 2, 1, 0, 1, 0, 6);
    drive(1, 6, 2, 0, 0, 1, 0, 6);
    drive(1, 6, 2, 0, 0, 1, 0, 6);
    // Back-pressure alone and idle decode.
    drive(1, 1, 2, 1, 0, 0, 0, 0);
    drive(0, 1, 2, 0, 0, 1, 1, 1);
    drive(0, 1, 2, 0, 0, 0, 1, 1);
    // Drive the jump counter into saturation.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 2, 0, 1, 1, 0, 0);
      drive(1, 1, 2, 0, 0, 1, 0, 0);
    end
    // Reset in the middle of a flush sequence.
    drive(1, 1, 2, 0, 1, 1, 0, 0);
    reset = 1'b0;
    drive(1, 1, 2, 0, 0, 1, 0, 0);
    reset = 1'b1;
    drive(1, 1, 2, 0, 0, 1, 0, 0);
    drive(1, 1, 2, 0, 0, 1, 0, 0);
    // Reset in the middle of a stall sequence.
    drive(1, 3, 2, 0, 0, 1, 1, 3);
    reset = 1'b0;
    drive(1, 3, 2, 0, 0, 1, 1, 3);
    reset = 1'b1;
    drive(1, 3, 2, 0, 0, 1, 0, 3);
    // Randomized traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      drive(($urandom_range(0, 7) != 0), 3'($urandom), 3'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 3'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
